aes_core_arbiter: RTL and testbench

AES_CORE_ARBITER -- requirements
Module: aes_core_arbiter

---
 rtl/aes_pkg.sv | 21 ++
 rtl/rr_arbiter2.sv | 19 +
 rtl/aes_core_arbiter.sv | 103 ++++++++++
 tb/tb_aes_core_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES core arbiter.
package aes_pkg;

    localparam int unsigned BLOCK_W         = 128;
    localparam int unsigned NUM_REQ         = 2;
    localparam int unsigned DEFAULT_TIMEOUT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Operand pair handed to the shared core for one job.
    typedef struct packed {
        logic [BLOCK_W-1:0] block;
        logic [BLOCK_W-1:0] key;
    } job_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant: a tie goes to the requester that was not granted last.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // One-hot (or zero) grant from the request pattern and the previous winner.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one AES core between two requesters, with a timeout abort and a held response.
module aes_core_arbiter
    import aes_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*BLOCK_W-1:0]   req_block,
    input  logic [NUM_REQ*BLOCK_W-1:0]   req_key,
    output logic                         core_start,
    output logic [BLOCK_W-1:0]           core_block,
    output logic [BLOCK_W-1:0]           core_key,
    input  logic                         core_done,
    input  logic [BLOCK_W-1:0]           core_result,
    output logic                         o_valid,
    input  logic                         o_ready,
    output logic [BLOCK_W-1:0]           o_block,
    output logic                         o_id,
    output logic                         o_err
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic             last_grant;
    logic [1:0]       grant;
    job_t             job_q;

    rr_arbiter2 u_arb (
        .valid      (req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Accept is same-cycle in IDLE; in every other state nobody is accepted.
    assign req_ready  = (state == IDLE) ? grant : 2'b00;
    assign core_block = job_q.block;
    assign core_key   = job_q.key;

    // Job sequencing: accept, start pulse, wait for done or timeout, hold response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            timer      <= '0;
            last_grant <= 1'b1;
            job_q      <= '0;
            core_start <= 1'b0;
            o_valid    <= 1'b0;
            o_block    <= '0;
            o_id       <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        o_id        <= grant[1];
                        job_q.block <= grant[1] ? req_block[2*BLOCK_W-1:BLOCK_W]
                                                : req_block[BLOCK_W-1:0];
                        job_q.key   <= grant[1] ? req_key[2*BLOCK_W-1:BLOCK_W]
                                                : req_key[BLOCK_W-1:0];
                        core_start  <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    // A done on the last timer cycle still counts as a completion.
                    if (core_done) begin
                        o_block <= core_result;
                        o_err   <= 1'b0;
                        o_valid <= 1'b1;
                        state   <= RESP;
                    end else if (timer == TMR_LAST) begin
                        o_block <= '0;
                        o_err   <= 1'b1;
                        o_valid <= 1'b1;
                        state   <= RESP;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                RESP: begin
                    if (o_ready) begin
                        o_valid    <= 1'b0;
                        last_grant <= o_id;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Self-checking bench for aes_core_arbiter with a behavioural stub core.
module tb_aes_core_arbiter;

    localparam int unsigned TIMEOUT = 32;
    localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [255:0] req_block;
    logic [255:0] req_key;
    logic         core_start;
    logic [127:0] core_block;
    logic [127:0] core_key;
    logic         core_done;
    logic [127:0] core_result;
    logic         o_valid;
    logic         o_ready;
    logic [127:0] o_block;
    logic         o_id;
    logic         o_err;

    aes_core_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_block   (req_block),
        .req_key     (req_key),
        .core_start  (core_start),
        .core_block  (core_block),
        .core_key    (core_key),
        .core_done   (core_done),
        .core_result (core_result),
        .o_valid     (o_valid),
        .o_ready     (o_ready),
        .o_block     (o_block),
        .o_id        (o_id),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    // Stand-in cipher: the known AES vector, otherwise a cheap keyed scramble.
    function automatic logic [127:0] aes_model(input logic [127:0] b, input logic [127:0] k);
        if (b == P0 && k == K0) return C0;
        return b ^ {k[63:0], k[127:64]} ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
    endfunction

    // Stub core: done pulses core_lat cycles after start; core_lat 0 never finishes.
    int           core_lat = 0;
    int           cnt = 0;
    logic [127:0] s_blk = '0;
    logic [127:0] s_key = '0;

    always @(posedge clk) begin
        if (core_start) begin
            cnt   <= core_lat;
            s_blk <= core_block;
            s_key <= core_key;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
        end
    end

    assign core_done   = (cnt == 1);
    assign core_result = aes_model(s_blk, s_key);

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: bound expired, expected DUT event", nm);
    endtask

    typedef struct {
        logic         id;
        logic [127:0] blk;
        logic         err;
    } resp_t;

    resp_t sb[$];

    int  cyc = 0;
    int  start_cyc = 0;
    int  last_lat = -1;
    int  n_start = 0;
    int  n_valid = 0;
    int  n_pop = 0;
    logic ov_d = 1'b0;

    // Monitor: latency bookkeeping and scoreboard compare on each response handshake.
    initial begin : monitor
        resp_t r;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset === 1'b1) begin
                if (core_start) begin
                    start_cyc = cyc;
                    n_start++;
                end
                if (o_valid && !ov_d) begin
                    last_lat = cyc - start_cyc;
                    n_valid++;
                end
                if (req_ready != 2'b00)
                    check("ready_outside_idle", 128'({o_valid, core_start}), 128'(0));
                if (o_valid && o_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_resp: got o_valid with id %0d, expected no response", o_id);
                    end else begin
                        r = sb.pop_front();
                        check("o_id", 128'(o_id), 128'(r.id));
                        check("o_block", o_block, r.blk);
                        check("o_err", 128'(o_err), 128'(r.err));
                    end
                    n_pop++;
                end
            end
            ov_d = o_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_req_ready"},  128'(req_ready),  128'(0));
        check({nm, "_core_start"}, 128'(core_start), 128'(0));
        check({nm, "_o_valid"},    128'(o_valid),    128'(0));
        check({nm, "_o_err"},      128'(o_err),      128'(0));
        check({nm, "_o_id"},       128'(o_id),       128'(0));
        check({nm, "_o_block"},    o_block,          128'(0));
        check({nm, "_core_block"}, core_block,       128'(0));
        check({nm, "_core_key"},   core_key,         128'(0));
    endtask

    // Wait for an accept; returns 1 when req_ready rose within the bound.
    task automatic wait_accept(output bit got);
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (req_ready != 2'b00) got = 1'b1;
        end
    endtask

    task automatic push_expected(input int exp_id, input logic exp_err, output resp_t r);
        r.id  = 1'(exp_id);
        r.err = exp_err;
        if (exp_err)
            r.blk = '0;
        else if (exp_id == 1)
            r.blk = aes_model(req_block[255:128], req_key[255:128]);
        else
            r.blk = aes_model(req_block[127:0], req_key[127:0]);
        sb.push_back(r);
    endtask

    task automatic wait_pop(input int pops0, output bit got);
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            #1;
            if (n_pop != pops0) got = 1'b1;
        end
    endtask

    // One full job with o_ready high; keep leaves req_valid asserted afterwards.
    task automatic run_job(input logic [1:0] v, input int lat, input int exp_id,
                           input int exp_lat, input logic exp_err, input bit keep);
        bit    got;
        int    pops0;
        resp_t r;
        tick();
        core_lat  = lat;
        req_valid = v;
        wait_accept(got);
        if (!got) begin
            fail_now("accept_wait");
            req_valid = 2'b00;
            return;
        end
        check("req_ready_grant", 128'(req_ready), 128'(exp_id == 1 ? 2'b10 : 2'b01));
        push_expected(exp_id, exp_err, r);
        pops0 = n_pop;
        tick();
        if (!keep) req_valid = 2'b00;
        wait_pop(pops0, got);
        if (!got) fail_now("resp_wait");
        else check("latency", 128'(last_lat), 128'(exp_lat));
    endtask

    typedef struct {
        logic [1:0] v;
        int         lat;
        int         exp_id;
        int         exp_lat;
        logic       exp_err;
    } vec_t;

    vec_t vecs[9];

    initial begin : main
        bit    got;
        int    ns;
        int    nv;
        int    pops0;
        resp_t r;

        vecs[0] = '{2'b11,  1, 0,  2, 1'b0};
        vecs[1] = '{2'b11, 10, 1, 11, 1'b0};
        vecs[2] = '{2'b01,  3, 0,  4, 1'b0};
        vecs[3] = '{2'b01,  5, 0,  6, 1'b0};
        vecs[4] = '{2'b10,  2, 1,  3, 1'b0};
        vecs[5] = '{2'b10,  0, 1, 33, 1'b1};
        vecs[6] = '{2'b11, 32, 0, 33, 1'b0};
        vecs[7] = '{2'b11, 33, 1, 33, 1'b1};
        vecs[8] = '{2'b01, 31, 0, 32, 1'b0};

        reset     = 1'b0;
        req_valid = 2'b00;
        o_ready   = 1'b1;
        req_block = {128'hfedcba98_76543210_01234567_89abcdef, P0};
        req_key   = {128'h13579bdf_2468ace0_0f1e2d3c_4b5a6978, K0};

        // Reset state, then idle with no requests.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("idle_no_req", 128'(req_ready), 128'(0));

        // Both requesters held valid: grants alternate starting from requester 0.
        run_job(2'b11, 10, 0, 11, 1'b0, 1'b1);
        run_job(2'b11, 10, 1, 11, 1'b0, 1'b1);
        run_job(2'b11, 10, 0, 11, 1'b0, 1'b1);
        run_job(2'b11, 10, 1, 11, 1'b0, 1'b0);

        // Table of grant patterns, core latencies and timeout boundaries.
        for (int i = 0; i < 9; i++) begin
            req_block[255:128] = {$urandom(), $urandom(), $urandom(), $urandom()};
            req_key[255:128]   = {$urandom(), $urandom(), $urandom(), $urandom()};
            run_job(vecs[i].v, vecs[i].lat, vecs[i].exp_id, vecs[i].exp_lat, vecs[i].exp_err, 1'b0);
        end

        // Response held under backpressure: stable outputs, no accept, no new start.
        tick();
        o_ready   = 1'b0;
        core_lat  = 4;
        req_valid = 2'b01;
        wait_accept(got);
        if (!got) fail_now("bp_accept_wait");
        check("bp_grant", 128'(req_ready), 128'(2'b01));
        push_expected(0, 1'b0, r);
        tick();
        req_valid = 2'b11;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (o_valid) got = 1'b1;
        end
        if (!got) fail_now("bp_valid_wait");
        #1;
        ns = n_start;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("bp_o_valid", 128'(o_valid), 128'(1));
            check("bp_o_block", o_block, r.blk);
            check("bp_o_id", 128'(o_id), 128'(0));
            check("bp_req_ready", 128'(req_ready), 128'(0));
        end
        #1;
        check("bp_no_start", 128'(n_start), 128'(ns));
        tick();
        o_ready   = 1'b1;
        req_valid = 2'b00;
        pops0 = n_pop - 1;
        if (sb.size() != 0) pops0 = n_pop;
        wait_pop(pops0, got);
        if (!got) fail_now("bp_resp_wait");

        // Reset during BUSY: job dropped, late done ignored, tie restarts at requester 0.
        tick();
        core_lat  = 20;
        req_valid = 2'b10;
        wait_accept(got);
        if (!got) fail_now("rst_accept_wait");
        check("rst_grant", 128'(req_ready), 128'(2'b10));
        tick();
        req_valid = 2'b00;
        repeat (5) tick();
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("midjob_reset");
        tick();
        reset = 1'b1;
        nv = n_valid;
        repeat (25) @(negedge clk);
        #1;
        check("late_done_no_valid", 128'(n_valid), 128'(nv));
        check_all_zero("after_late_done");
        run_job(2'b11, 2, 0, 3, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("sb_drained", 128'(sb.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
